// File: rtl/stream_padding.sv
// Streams K channel-major planes of H x W pixels and surrounds each plane with a
// PAD-pixel border of PAD_VALUE, over valid/ready with a registered output stage.
module stream_padding #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned K          = 1,
  parameter int unsigned H          = 1,
  parameter int unsigned W          = 1,
  parameter int unsigned PAD        = 1,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_eop,
  output logic                  out_last,
  output logic                  busy
);

  localparam int unsigned OW = W + 2 * PAD;
  localparam int unsigned OH = H + 2 * PAD;
  localparam int unsigned CW = (OW > 1) ? $clog2(OW) : 1;
  localparam int unsigned RW = (OH > 1) ? $clog2(OH) : 1;
  localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state, state_d;
  logic [CW-1:0]         col, col_d;
  logic [RW-1:0]         row, row_d;
  logic [KW-1:0]         ch, ch_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  valid_d, eop_d, last_d;
  logic                  load, step, border;
  logic                  col_end, row_end, ch_end;

  // Border test; with no padding every position is interior.
  generate
    if (PAD == 0) begin : g_nopad
      assign border = 1'b0;
    end else begin : g_pad
      assign border = (32'(row) < PAD) || (32'(row) >= H + PAD) ||
                      (32'(col) < PAD) || (32'(col) >= W + PAD);
    end
  endgenerate

  assign col_end = (col == CW'(OW - 1));
  assign row_end = (row == RW'(OH - 1));
  assign ch_end  = (ch == KW'(K - 1));
  assign load    = !out_valid || out_ready;
  assign busy    = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      ch        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_eop   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_d;
      col       <= col_d;
      row       <= row_d;
      ch        <= ch_d;
      out_data  <= data_d;
      out_valid <= valid_d;
      out_eop   <= eop_d;
      out_last  <= last_d;
    end
  end

  // RUN is only entered once a pixel is waiting, so border never outruns data.
  always_comb begin
    state_d  = state;
    col_d    = col;
    row_d    = row;
    ch_d     = ch;
    data_d   = out_data;
    valid_d  = out_valid;
    eop_d    = out_eop;
    last_d   = out_last;
    in_ready = 1'b0;
    step     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        in_ready = load && !border;
        step     = load && (border || in_valid);
        if (step) begin
          valid_d = 1'b1;
          data_d  = border ? PAD_VALUE : in_data;
          eop_d   = col_end && row_end;
          last_d  = col_end && row_end && ch_end;
          if (col_end) begin
            col_d = '0;
            if (row_end) begin
              row_d = '0;
              if (ch_end) begin
                ch_d    = '0;
                state_d = IDLE;
              end else begin
                ch_d = ch + KW'(1);
              end
            end else begin
              row_d = row + RW'(1);
            end
          end else begin
            col_d = col + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Drained with nothing new to load: output register empties.
    if (!step && out_ready) begin
      valid_d = 1'b0;
      eop_d   = 1'b0;
      last_d  = 1'b0;
    end
  end

endmodule
